// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the RISC-V core.
// Issues loads/stores on a req/gnt + rvalid data bus, formats load data,
// selects the writeback value and drives the registered MEM/WB interface.
// Optional response timeout: define MEM_TIMEOUT_EN to enable the WAIT_RSP
// cycle counter (limit set by TIMEOUT_CYCLES).
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        rf_we,
    input  logic [1:0]  rf_wsel,
    input  logic        ram_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] rf_rdata2,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic [31:0] alu_c,
    output logic        mem_stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        mem_fault
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_wb_valid;
    logic        r_wb_we;
    logic [4:0]  r_wb_waddr;
    logic [31:0] r_wb_wdata;
    logic        r_mem_fault;

    logic        w_load;
    logic        w_store;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_issue;
    logic        w_wait;
    logic        w_timeout;
    logic        w_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;

    assign w_load   = in_valid & rf_we & (rf_wsel == 2'b01);
    assign w_store  = in_valid & ram_we;
    assign w_mem_op = w_load | w_store;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    assign w_misalign = w_mem_op &
                        (((mem_funct3[1:0] == 2'b01) & alu_c[0]) |
                         ((mem_funct3[1:0] == 2'b10) & (alu_c[1:0] != 2'b00)));

    assign w_issue = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
    assign w_wait  = (r_state == S_WAIT_RSP);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = w_wait & ~dbus_rvalid & (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Count cycles spent waiting for a response; zero whenever idle so each access starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_wait) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    // No timeout in this build: WAIT_RSP waits for rvalid indefinitely.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    assign w_fault   = w_misalign | w_timeout;
    assign mem_stall = w_issue | (w_wait & ~dbus_rvalid & ~w_timeout);

    // Request is masked by reset so it drops the moment reset asserts.
    assign dbus_req  = w_issue & rst_n;
    assign dbus_we   = w_store;
    assign dbus_addr = {alu_c[31:2], 2'b00};

    // Store lane steering: strobes select the addressed bytes, data replicated across lanes.
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        dbus_wstrb = 4'b0000;
        dbus_wdata = rf_rdata2;
        case (mem_funct3[1:0])
            2'b00: begin
                dbus_wstrb = 4'b0001 << alu_c[1:0];
                dbus_wdata = {4{rf_rdata2[7:0]}};
            end
            2'b01: begin
                dbus_wstrb = alu_c[1] ? 4'b1100 : 4'b0011;
                dbus_wdata = {2{rf_rdata2[15:0]}};
            end
            default: begin
                dbus_wstrb = 4'b1111;
                dbus_wdata = rf_rdata2;
            end
        endcase
        if (!w_store) begin
            dbus_wstrb = 4'b0000;
        end
    end

    // Load formatting: pick the addressed byte/half and extend per funct3.
    always_comb begin
        w_byte = dbus_rdata[7:0];
        case (alu_c[1:0])
            2'b00: w_byte = dbus_rdata[7:0];
            2'b01: w_byte = dbus_rdata[15:8];
            2'b10: w_byte = dbus_rdata[23:16];
            2'b11: w_byte = dbus_rdata[31:24];
            default: w_byte = dbus_rdata[7:0];
        endcase
        w_half      = alu_c[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        w_load_data = dbus_rdata;
        case (mem_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dbus_rdata;
        endcase
    end

    // Writeback source select.
    always_comb begin
        w_wb_data = 32'd0;
        case (rf_wsel)
            2'b00:   w_wb_data = alu_c;
            2'b01:   w_wb_data = w_load_data;
            2'b10:   w_wb_data = rf_wdata;
            default: w_wb_data = 32'd0;
        endcase
    end

    // Bus FSM: hold the request until granted, then wait for the response (or timeout).
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_issue && dbus_gnt) r_state <= S_WAIT_RSP;
                S_WAIT_RSP: if (dbus_rvalid || w_timeout) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: capture when the stage advances, insert a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_waddr  <= 5'd0;
            r_wb_wdata  <= 32'd0;
            r_mem_fault <= 1'b0;
        end else if (!mem_stall) begin
            r_wb_valid  <= in_valid;
            r_wb_we     <= rf_we & in_valid & (rf_waddr != 5'd0) & ~w_fault;
            r_wb_waddr  <= rf_waddr;
            r_wb_wdata  <= w_wb_data;
            r_mem_fault <= w_fault;
        end else begin
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_mem_fault <= 1'b0;
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_we     = r_wb_we;
    assign wb_waddr  = r_wb_waddr;
    assign wb_wdata  = r_wb_wdata;
    assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Table-driven single-cycle vectors, hand-written bus sequences, and random
// aligned loads/stores checked against a byte-lane arithmetic model.
// The timeout sequence is compiled only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        ram_we;
    logic [2:0]  mem_funct3;
    logic [31:0] rf_rdata2;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_c;
    logic        mem_stall;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mem_fault;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .ram_we(ram_we), .mem_funct3(mem_funct3),
        .rf_rdata2(rf_rdata2), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_c(alu_c), .mem_stall(mem_stall), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 2'b00;
        ram_we      = 1'b0;
        mem_funct3  = 3'b000;
        rf_rdata2   = 32'd0;
        rf_waddr    = 5'd0;
        rf_wdata    = 32'd0;
        alu_c       = 32'd0;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'd0;
    endtask

    // Reference model: access size is 2**funct3[1:0] bytes at byte offset addr[1:0].
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata,
                         output logic [3:0] strb, output logic [31:0] wd,
                         output logic [31:0] ld);
        int          size;
        int          off;
        logic [63:0] v;
        size = 1 << f3[1:0];
        off  = int'(addr[1:0]);
        strb = st ? 4'(((1 << size) - 1) << off) : 4'd0;
        for (int k = 0; k < 4; k++) wd[8*k +: 8] = data[8*(k % size) +: 8];
        v = ({32'd0, rdata} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
        ld = v[31:0];
    endtask

    // One aligned memory access: grant after gd extra cycles, response rd cycles after grant.
    task automatic do_mem(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input int gd, input int rd,
                          input logic [31:0] rdata);
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        int          stalls;
        logic        req_ok;
        model(st, f3, addr, data, rdata, e_strb, e_wd, e_ld);
        in_valid   = 1'b1;
        rf_we      = ~st;
        rf_wsel    = st ? 2'b00 : 2'b01;
        ram_we     = st;
        mem_funct3 = f3;
        rf_rdata2  = data;
        alu_c      = addr;
        rf_waddr   = waddr;
        rf_wdata   = $urandom;
        stalls     = 0;
        req_ok     = 1'b1;
        for (int i = 0; i <= gd; i++) begin
            dbus_gnt = (i == gd);
            @(negedge clk);
            check({tag, " addr"}, dbus_addr, {addr[31:2], 2'b00});
            check({tag, " we"}, dbus_we, st);
            check({tag, " wstrb"}, dbus_wstrb, e_strb);
            if (st) check({tag, " wdata"}, dbus_wdata, e_wd);
            if (dbus_req !== 1'b1) req_ok = 1'b0;
            if (mem_stall === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        dbus_gnt = 1'b0;
        for (int j = 0; j <= rd; j++) begin
            dbus_rvalid = (j == rd);
            dbus_rdata  = (j == rd) ? rdata : $urandom;
            @(negedge clk);
            if (j == 0) check({tag, " wb_valid bubble"}, wb_valid, 1'b0);
            if (dbus_req !== 1'b0) req_ok = 1'b0;
            if (mem_stall === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        dbus_rvalid = 1'b0;
        idle_inputs();
        check({tag, " req pattern"}, req_ok, 1'b1);
        check({tag, " stall cycles"}, stalls, gd + 1 + rd);
        check({tag, " wb_valid"}, wb_valid, 1'b1);
        check({tag, " wb_we"}, wb_we, (!st && waddr != 5'd0));
        check({tag, " wb_waddr"}, wb_waddr, waddr);
        check({tag, " wb_wdata"}, wb_wdata, st ? addr : e_ld);
        check({tag, " mem_fault"}, mem_fault, 1'b0);
    endtask

    typedef struct {
        logic        in_valid;
        logic        rf_we;
        logic [1:0]  wsel;
        logic        ram_we;
        logic [2:0]  f3;
        logic [31:0] alu_c;
        logic [31:0] rf_wdata;
        logic [4:0]  waddr;
        logic        exp_valid;
        logic        exp_we;
        logic        exp_fault;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // ALU ops, bubble, x0 write, misaligned accesses (dbus_rdata held at 0).
        vecs[0] = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         5'd5,  1'b1, 1'b1, 1'b0, 32'h0000_1234};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 1'b0, 3'b000, 32'h0000_0055, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 2'b11, 1'b0, 3'b000, 32'h0000_0077, 32'h0000_0099, 5'd3,  1'b1, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_AAAA, 32'h0,         5'd7,  1'b0, 1'b0, 1'b0, 32'h0000_AAAA};
        vecs[4] = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_0042, 32'h0,         5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0042};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0301, 32'h0,         5'd9,  1'b1, 1'b0, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0203, 32'h0,         5'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0203};
        vecs[7] = '{1'b1, 1'b1, 2'b01, 1'b0, 3'b101, 32'h0000_0011, 32'h0,         5'd4,  1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_0001, 32'h0,         5'd1,  1'b1, 1'b1, 1'b0, 32'h0000_0001};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset wb_valid", wb_valid, 1'b0);
        check("reset wb_we", wb_we, 1'b0);
        check("reset wb_waddr", wb_waddr, 5'd0);
        check("reset wb_wdata", wb_wdata, 32'd0);
        check("reset mem_fault", mem_fault, 1'b0);
        check("reset dbus_req", dbus_req, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle vectors: never stall, never request, result one cycle later.
        for (int v = 0; v < 9; v++) begin
            in_valid   = vecs[v].in_valid;
            rf_we      = vecs[v].rf_we;
            rf_wsel    = vecs[v].wsel;
            ram_we     = vecs[v].ram_we;
            mem_funct3 = vecs[v].f3;
            alu_c      = vecs[v].alu_c;
            rf_wdata   = vecs[v].rf_wdata;
            rf_waddr   = vecs[v].waddr;
            @(negedge clk);
            check($sformatf("vec%0d stall", v), mem_stall, 1'b0);
            check($sformatf("vec%0d req", v), dbus_req, 1'b0);
            @(posedge clk); #1;
            check($sformatf("vec%0d wb_valid", v), wb_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d wb_we", v), wb_we, vecs[v].exp_we);
            check($sformatf("vec%0d wb_waddr", v), wb_waddr, vecs[v].waddr);
            check($sformatf("vec%0d wb_wdata", v), wb_wdata, vecs[v].exp_wdata);
            check($sformatf("vec%0d mem_fault", v), mem_fault, vecs[v].exp_fault);
        end
        idle_inputs();
        @(posedge clk); #1;
        check("fault pulse cleared", mem_fault, 1'b0);

        // Directed bus sequences.
        do_mem("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd8, 0, 0, 32'h80FF_0000);
        do_mem("sh", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd10, 3, 2, 32'h0);
        do_mem("lw x0", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 1, 1, 32'h1234_5678);
        do_mem("lhu", 1'b0, 3'b101, 32'h0000_0502, 32'h0, 5'd12, 0, 1, 32'h8765_4321);

        // Reset asserted mid-access; a late rvalid must be ignored.
        in_valid   = 1'b1;
        rf_we      = 1'b1;
        rf_wsel    = 2'b01;
        mem_funct3 = 3'b010;
        alu_c      = 32'h0000_0600;
        rf_waddr   = 5'd6;
        dbus_gnt   = 1'b1;
        @(negedge clk);
        check("rst seq req", dbus_req, 1'b1);
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        @(negedge clk);
        check("rst seq wait stall", mem_stall, 1'b1);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check("late rvalid stall", mem_stall, 1'b0);
        check("late rvalid req", dbus_req, 1'b0);
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        check("late rvalid wb_valid", wb_valid, 1'b0);
        check("late rvalid wb_we", wb_we, 1'b0);
        check("late rvalid wb_waddr", wb_waddr, 5'd0);
        check("late rvalid wb_wdata", wb_wdata, 32'd0);
        do_mem("post reset lw", 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd2, 0, 0, 32'h0BAD_C0DE);

        // Reset drops a pending request immediately.
        in_valid   = 1'b1;
        ram_we     = 1'b1;
        mem_funct3 = 3'b010;
        alu_c      = 32'h0000_0800;
        @(negedge clk);
        check("pre reset req", dbus_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("req drops in reset", dbus_req, 1'b0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // No response: stall held for 4 WAIT_RSP cycles, released on the 5th with a fault.
        in_valid   = 1'b1;
        rf_we      = 1'b1;
        rf_wsel    = 2'b01;
        mem_funct3 = 3'b010;
        alu_c      = 32'h0000_0900;
        rf_waddr   = 5'd11;
        dbus_gnt   = 1'b1;
        @(posedge clk); #1;
        dbus_gnt = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("timeout stall c%0d", j), mem_stall, (j < 4));
            @(posedge clk); #1;
        end
        idle_inputs();
        check("timeout mem_fault", mem_fault, 1'b1);
        check("timeout wb_we", wb_we, 1'b0);
        check("timeout wb_valid", wb_valid, 1'b1);
        @(posedge clk); #1;
        check("timeout fault pulse", mem_fault, 1'b0);
`endif

        // Randomized aligned accesses against the model.
        for (int n = 0; n < 40; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          sel;
            st = 1'($urandom_range(0, 1));
            if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            addr = $urandom;
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            do_mem($sformatf("rnd%0d", n), st, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
